mem_bus_bridge: RTL and testbench

Sequences every CPU data-memory access onto the shared system bus: decodes the address to one of four slaves, drives a registered request, waits for the slave's acknowledge, and returns read data or a bus error. It sits between the MEM stage and the data memory, two timers and interrupt generator, stalling the pipeline while an access is in flight. It consumes the already-legal byte enables and write data produced in the MEM stage. It never re-checks alignment.

---
 rtl/mips_bus_pkg.sv | 33 +++
 rtl/bus_addr_decode.sv | 19 +
 rtl/mem_bus_bridge.sv | 150 +++++++++++++++
 tb/tb_mem_bus_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the CPU data-side bus: slave address map, slave
// indices and the bridge state encoding.
package mips_bus_pkg;

    localparam int NUM_SLV = 4;

    localparam int SLV_DM  = 0;
    localparam int SLV_TC0 = 1;
    localparam int SLV_TC1 = 2;
    localparam int SLV_IG  = 3;

    // Inclusive byte-address bounds of each slave window
    localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
    localparam logic [31:0] TC0_LO = 32'h0000_7F00;
    localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
    localparam logic [31:0] TC1_LO = 32'h0000_7F10;
    localparam logic [31:0] TC1_HI = 32'h0000_7F1B;
    localparam logic [31:0] IG_LO  = 32'h0000_7F20;
    localparam logic [31:0] IG_HI  = 32'h0000_7F23;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bridge_state_e;

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: maps a byte address onto the one-hot slave
// select of the system bus. Shared by the data and instruction-fetch sides.
module bus_addr_decode
    import mips_bus_pkg::*;
(
    input  logic [31:0]        addr_i,
    output logic               hit_o,
    output logic [NUM_SLV-1:0] sel_o
);

    // DM starts at address zero, so only its upper bound needs a compare
    assign sel_o[SLV_DM]  = (addr_i <= DM_HI);
    assign sel_o[SLV_TC0] = in_range(addr_i, TC0_LO, TC0_HI);
    assign sel_o[SLV_TC1] = in_range(addr_i, TC1_LO, TC1_HI);
    assign sel_o[SLV_IG]  = in_range(addr_i, IG_LO, IG_HI);

    assign hit_o = |sel_o;

endmodule

// File: rtl/mem_bus_bridge.sv
// Sequences MEM-stage loads/stores onto the shared system bus: registered
// request, wait for the selected slave's ack or a timeout, then one-cycle response.
module mem_bus_bridge #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic        cpu_kill,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_byteen,
    input  logic [31:0] cpu_wd,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic        cpu_buserr,
    output logic [31:0] cpu_rdata,
    output logic [3:0]  dev_sel,
    output logic        dev_we,
    output logic [31:0] dev_addr,
    output logic [3:0]  dev_byteen,
    output logic [31:0] dev_wd,
    input  logic [3:0]  dev_ack,
    input  logic [31:0] dm_rd,
    input  logic [31:0] tc0_rd,
    input  logic [31:0] tc1_rd,
    input  logic [31:0] ig_rd
);
    import mips_bus_pkg::*;

    bridge_state_e state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wd_q, wd_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [3:0]       byteen_q, byteen_d;
    logic [3:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic             buserr_q, buserr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req;
    logic             hit;
    logic [3:0]       dec_sel;
    logic             ack;
    logic [31:0]      slave_rd;

    bus_addr_decode u_decode (
        .addr_i (cpu_addr),
        .hit_o  (hit),
        .sel_o  (dec_sel)
    );

    assign req = (cpu_re | cpu_we) & ~cpu_kill;
    assign ack = |(dev_ack & sel_q);

    // sel_q is one-hot while in ACCESS, so an AND-OR mux is sufficient
    assign slave_rd = ({32{sel_q[SLV_DM]}}  & dm_rd)
                    | ({32{sel_q[SLV_TC0]}} & tc0_rd)
                    | ({32{sel_q[SLV_TC1]}} & tc1_rd)
                    | ({32{sel_q[SLV_IG]}}  & ig_rd);

    // NOTE: every next-state signal gets its hold value first so that no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        rdata_d  = rdata_q;
        byteen_d = byteen_q;
        sel_d    = sel_q;
        we_d     = we_q;
        buserr_d = buserr_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        addr_d   = cpu_addr;
                        wd_d     = cpu_wd;
                        we_d     = cpu_we;
                        byteen_d = cpu_we ? cpu_byteen : 4'b0000;
                        sel_d    = dec_sel;
                        cnt_d    = '0;
                        buserr_d = 1'b0;
                        state_d  = ST_ACCESS;
                    end else begin
                        buserr_d = 1'b1;
                        rdata_d  = '0;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                if (ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    // Ack wins over timeout when both land in the last cycle
                    rdata_d  = (ack && !we_q) ? slave_rd : 32'h0;
                    buserr_d = !ack;
                    sel_d    = '0;
                    we_d     = 1'b0;
                    byteen_d = '0;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wd_q     <= '0;
            rdata_q  <= '0;
            byteen_q <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            buserr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            rdata_q  <= rdata_d;
            byteen_q <= byteen_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            buserr_q <= buserr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cpu_stall  = ~reset & (((state_q == ST_IDLE) & req) | (state_q == ST_ACCESS));
    assign cpu_done   = (state_q == ST_RESP);
    assign cpu_buserr = (state_q == ST_RESP) & buserr_q;
    assign cpu_rdata  = rdata_q;

    assign dev_sel    = sel_q;
    assign dev_we     = we_q;
    assign dev_addr   = addr_q;
    assign dev_byteen = byteen_q;
    assign dev_wd     = wd_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed self-checking bench for mem_bus_bridge: hits, miss, timeout,
// kill handling and asynchronous reset in the middle of an access.
module tb_mem_bus_bridge;

    logic        clk;
    logic        reset;
    logic        cpu_re, cpu_we, cpu_kill;
    logic [31:0] cpu_addr, cpu_wd;
    logic [3:0]  cpu_byteen;
    logic        cpu_stall, cpu_done, cpu_buserr;
    logic [31:0] cpu_rdata;
    logic [3:0]  dev_sel;
    logic        dev_we;
    logic [31:0] dev_addr;
    logic [3:0]  dev_byteen;
    logic [31:0] dev_wd;
    logic [3:0]  dev_ack;
    logic [31:0] dm_rd, tc0_rd, tc1_rd, ig_rd;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          lat;
        int          stall_cyc;
        int          sel_cyc;
        logic [3:0]  sel;
        logic [3:0]  be;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } obs_t;

    obs_t o;

    mem_bus_bridge #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_kill   (cpu_kill),
        .cpu_addr   (cpu_addr),
        .cpu_byteen (cpu_byteen),
        .cpu_wd     (cpu_wd),
        .cpu_stall  (cpu_stall),
        .cpu_done   (cpu_done),
        .cpu_buserr (cpu_buserr),
        .cpu_rdata  (cpu_rdata),
        .dev_sel    (dev_sel),
        .dev_we     (dev_we),
        .dev_addr   (dev_addr),
        .dev_byteen (dev_byteen),
        .dev_wd     (dev_wd),
        .dev_ack    (dev_ack),
        .dm_rd      (dm_rd),
        .tc0_rd     (tc0_rd),
        .tc1_rd     (tc1_rd),
        .ig_rd      (ig_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and hold it until cpu_done. ack_k = ACCESS cycle in
    // which ack_line is raised (0 = never); kill_in_access raises cpu_kill
    // for every ACCESS cycle. Observations of the first ACCESS cycle are kept.
    task automatic run_access(input logic re, input logic we,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input int ack_k,
                              input logic [3:0] ack_line, input logic kill_in_access,
                              output obs_t r);
        r = '{lat: 0, stall_cyc: 0, sel_cyc: 0, sel: 4'h0, be: 4'h0, we: 1'b0,
              addr: 32'h0, wd: 32'h0, err: 1'b0, rd: 32'h0};
        cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wd = wd; cpu_byteen = be;
        cpu_kill = 1'b0; dev_ack = 4'h0;
        #1;
        while (!cpu_done && r.lat < 40) begin
            if (cpu_stall) r.stall_cyc++;
            if (dev_sel != 4'h0) begin
                r.sel_cyc++;
                if (r.sel_cyc == 1) begin
                    r.sel = dev_sel; r.be = dev_byteen; r.we = dev_we;
                    r.addr = dev_addr; r.wd = dev_wd;
                end
                cpu_kill = kill_in_access;
                dev_ack  = (ack_k > 0 && r.sel_cyc == ack_k) ? ack_line : 4'h0;
            end
            tick();
            dev_ack = 4'h0;
            r.lat++;
        end
        r.err = cpu_buserr;
        r.rd  = cpu_rdata;
        cpu_re = 1'b0; cpu_we = 1'b0; cpu_kill = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        cpu_re = 1'b1; cpu_we = 1'b0; cpu_kill = 1'b0;
        cpu_addr = 32'h0000_0010; cpu_wd = 32'h0; cpu_byteen = 4'h0;
        dev_ack = 4'h0;
        dm_rd  = 32'hCAFE_0001;
        tc0_rd = 32'h1111_2222;
        tc1_rd = 32'hDEAD_BEEF;
        ig_rd  = 32'h5555_AAAA;

        tick(); tick();
        check("reset_stall",  {31'b0, cpu_stall}, 32'h0);
        check("reset_done",   {31'b0, cpu_done}, 32'h0);
        check("reset_sel",    {28'b0, dev_sel}, 32'h0);
        check("reset_rdata",  cpu_rdata, 32'h0);
        cpu_re = 1'b0;
        reset  = 1'b0;
        tick();

        // sw 0x12345678 -> 0x0010, DM acks in first ACCESS cycle
        run_access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1, 4'b0001, 1'b0, o);
        check("sw_lat",    o.lat, 2);
        check("sw_stall",  o.stall_cyc, 2);
        check("sw_sel",    {28'b0, o.sel}, 32'h1);
        check("sw_be",     {28'b0, o.be}, 32'hF);
        check("sw_we",     {31'b0, o.we}, 32'h1);
        check("sw_addr",   o.addr, 32'h0000_0010);
        check("sw_wd",     o.wd, 32'h1234_5678);
        check("sw_err",    {31'b0, o.err}, 32'h0);
        check("sw_sel_released", {28'b0, dev_sel}, 32'h0);

        // lw 0x7F14: TC1 acks in third ACCESS cycle
        run_access(1'b1, 1'b0, 32'h0000_7F14, 32'h0, 4'hF, 3, 4'b0100, 1'b0, o);
        check("lw_tc1_lat",  o.lat, 4);
        check("lw_tc1_sel",  {28'b0, o.sel}, 32'h4);
        check("lw_tc1_be",   {28'b0, o.be}, 32'h0);
        check("lw_tc1_rd",   o.rd, 32'hDEAD_BEEF);
        check("lw_tc1_err",  {31'b0, o.err}, 32'h0);
        tick();
        check("rdata_hold",  cpu_rdata, 32'hDEAD_BEEF);

        // sw to TC0, ack in second cycle: write returns zero read data
        run_access(1'b0, 1'b1, 32'h0000_7F04, 32'hA5A5_A5A5, 4'hF, 2, 4'b0010, 1'b0, o);
        check("sw_tc0_lat",  o.lat, 3);
        check("sw_tc0_sel",  {28'b0, o.sel}, 32'h2);
        check("sw_tc0_rd",   o.rd, 32'h0);

        // lw 0x3000: first address past DM is a decode miss
        run_access(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, 4'h0, 1'b0, o);
        check("miss_lat",    o.lat, 1);
        check("miss_sel",    {28'b0, o.sel}, 32'h0);
        check("miss_err",    {31'b0, o.err}, 32'h1);
        check("miss_rd",     o.rd, 32'h0);

        // Upper inclusive bound of TC0 decodes, one past it misses
        run_access(1'b1, 1'b0, 32'h0000_7F0B, 32'h0, 4'hF, 1, 4'b0010, 1'b0, o);
        check("tc0_hi_rd",   o.rd, 32'h1111_2222);
        run_access(1'b1, 1'b0, 32'h0000_7F0C, 32'h0, 4'hF, 0, 4'h0, 1'b0, o);
        check("tc0_hi1_err", {31'b0, o.err}, 32'h1);

        // sb 0x7F20 lanes 0100, IG never acks -> timeout
        run_access(1'b0, 1'b1, 32'h0000_7F20, 32'h0077_0000, 4'b0100, 0, 4'h0, 1'b0, o);
        check("to_lat",      o.lat, 17);
        check("to_sel_cyc",  o.sel_cyc, 16);
        check("to_sel",      {28'b0, o.sel}, 32'h8);
        check("to_be",       {28'b0, o.be}, 32'h4);
        check("to_err",      {31'b0, o.err}, 32'h1);

        // Ack arriving in the very last ACCESS cycle still counts as success
        run_access(1'b1, 1'b0, 32'h0000_7F20, 32'h0, 4'hF, 16, 4'b1000, 1'b0, o);
        check("ack16_lat",   o.lat, 17);
        check("ack16_err",   {31'b0, o.err}, 32'h0);
        check("ack16_rd",    o.rd, 32'h5555_AAAA);

        // Ack only on an unselected line is ignored
        run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1, 4'b1110, 1'b0, o);
        check("wrong_ack_lat", o.lat, 17);
        check("wrong_ack_err", {31'b0, o.err}, 32'h1);

        // cpu_kill with a request in IDLE: nothing is accepted
        cpu_re = 1'b1; cpu_kill = 1'b1; cpu_addr = 32'h0000_0020;
        #1;
        check("kill_idle_stall", {31'b0, cpu_stall}, 32'h0);
        tick();
        check("kill_idle_sel",   {28'b0, dev_sel}, 32'h0);
        tick();
        check("kill_idle_done",  {31'b0, cpu_done}, 32'h0);
        cpu_re = 1'b0; cpu_kill = 1'b0;
        tick();

        // cpu_kill during ACCESS is ignored
        run_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 2, 4'b0001, 1'b1, o);
        check("kill_acc_lat", o.lat, 3);
        check("kill_acc_rd",  o.rd, 32'hCAFE_0001);
        check("kill_acc_err", {31'b0, o.err}, 32'h0);

        // Asynchronous reset in the middle of an access
        cpu_we = 1'b1; cpu_addr = 32'h0000_0040; cpu_wd = 32'hFFFF_0000; cpu_byteen = 4'hC;
        tick(); tick();
        check("mid_sel_before", {28'b0, dev_sel}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_sel",   {28'b0, dev_sel}, 32'h0);
        check("mid_rst_we",    {31'b0, dev_we}, 32'h0);
        check("mid_rst_be",    {28'b0, dev_byteen}, 32'h0);
        check("mid_rst_addr",  dev_addr, 32'h0);
        check("mid_rst_wd",    dev_wd, 32'h0);
        check("mid_rst_stall", {31'b0, cpu_stall}, 32'h0);
        check("mid_rst_done",  {31'b0, cpu_done}, 32'h0);
        cpu_we = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        run_access(1'b0, 1'b1, 32'h0000_2FFC, 32'h0BAD_F00D, 4'h3, 1, 4'b0001, 1'b0, o);
        check("post_rst_lat",  o.lat, 2);
        check("post_rst_sel",  {28'b0, o.sel}, 32'h1);
        check("post_rst_be",   {28'b0, o.be}, 32'h3);
        check("post_rst_wd",   o.wd, 32'h0BAD_F00D);
        check("post_rst_err",  {31'b0, o.err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
